// File: rtl/genetic_pkg.sv
// genetic_pkg: shared types and constants for the evolvable logic-element array.
//   LE_CFG_W / FUNC_W / SEL_W : width of one element configuration and its fields
//   NUM_INPUTS_DEF            : default size of the input bus each element selects from
//   func_e                    : element function codes
//   le_cfg_t                  : one element configuration {ins_b, ins_a, func}
//   sel_out_of_range()        : true when an input select addresses a nonexistent input
package genetic_pkg;

  localparam int LE_CFG_W       = 13;
  localparam int FUNC_W         = 3;
  localparam int SEL_W          = 5;
  localparam int NUM_INPUTS_DEF = 26;

  typedef enum logic [FUNC_W-1:0] {
    AND  = 3'd0,
    OR   = 3'd1,
    NOT  = 3'd2,
    XOR  = 3'd3,
    XNOR = 3'd4,
    NAND = 3'd5,
    NOR  = 3'd6,
    BUF  = 3'd7
  } func_e;

  typedef struct packed {
    logic [SEL_W-1:0] ins_b;
    logic [SEL_W-1:0] ins_a;
    func_e            func;
  } le_cfg_t;

  function automatic logic sel_out_of_range(input logic [SEL_W-1:0] sel, input int num_inputs);
    return int'(sel) >= num_inputs;
  endfunction

endpackage

// File: rtl/genome_loader_if.sv
// genome_loader_if: byte-stream valid/ready channel carrying the chromosome.
//   in_data  : chromosome byte        (master -> slave)
//   in_valid : in_data valid          (master -> slave)
//   in_ready : slave accepts this cycle (slave -> master)
interface genome_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/genome_loader.sv
// genome_loader: unpacks a chromosome byte stream into per-element shadow
// configurations and atomically commits them to the live configuration.
//   clk, reset     : clock and synchronous active-high reset
//   bus            : genome_loader_if.slave byte stream (in_data/in_valid/in_ready)
//   abort          : drop the partial frame and return to IDLE
//   conf_func_all  : live function selects, element k at [3k+2:3k]
//   conf_ins_all   : live input selects, element k at [10k+9:10k]
//   busy           : frame in progress
//   load_done      : one-cycle pulse, commit performed
//   load_error     : one-cycle pulse, frame rejected
// Optional feature macro: GENOME_CHECKSUM_EN adds a trailing XOR checksum byte.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for first byte (byte A of element 0)
// LOAD_A  | expecting byte A of element idx
// LOAD_B  | expecting byte B of element idx
// CHECK   | expecting checksum byte (GENOME_CHECKSUM_EN only)
// COMMIT  | one cycle: copy shadow to live, or report rejection
module genome_loader
  import genetic_pkg::*;
#(
  parameter int NUM_LE     = 18,
  parameter int NUM_INPUTS = NUM_INPUTS_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  genome_loader_if.slave           bus,
  input  logic                     abort,
  output logic [FUNC_W*NUM_LE-1:0] conf_func_all,
  output logic [2*SEL_W*NUM_LE-1:0] conf_ins_all,
  output logic                     busy,
  output logic                     load_done,
  output logic                     load_error
);

  localparam int IDX_W = (NUM_LE > 1) ? $clog2(NUM_LE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LE - 1);

`ifdef GENOME_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_CHECK, S_COMMIT} state_e;
  logic [7:0] csum_q, csum_d;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_COMMIT} state_e;
`endif

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             rej_q, rej_d;
  logic             xfer, wr_a, wr_b, commit_en;
  logic             range_a, range_b;

  // in_ready depends only on state; reset gating keeps it low while in reset.
  assign bus.in_ready = !reset && (state_q != S_COMMIT);
  assign xfer    = bus.in_valid && bus.in_ready && !abort;
  assign range_a = sel_out_of_range(bus.in_data[7:3], NUM_INPUTS);
  assign range_b = sel_out_of_range(bus.in_data[4:0], NUM_INPUTS);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_d     = err_q;
    done_d    = 1'b0;
    rej_d     = 1'b0;
    wr_a      = 1'b0;
    wr_b      = 1'b0;
    commit_en = 1'b0;
`ifdef GENOME_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        err_d = 1'b0;
`ifdef GENOME_CHECKSUM_EN
        csum_d = 8'h00;
`endif
        if (xfer) begin
          wr_a    = 1'b1;
          err_d   = range_a;
`ifdef GENOME_CHECKSUM_EN
          csum_d  = bus.in_data;
`endif
          state_d = S_LOAD_B;
        end
      end
      S_LOAD_A: begin
        if (xfer) begin
          wr_a    = 1'b1;
          err_d   = err_q | range_a;
`ifdef GENOME_CHECKSUM_EN
          csum_d  = csum_q ^ bus.in_data;
`endif
          state_d = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        if (xfer) begin
          wr_b  = 1'b1;
          err_d = err_q | range_b;
`ifdef GENOME_CHECKSUM_EN
          csum_d = csum_q ^ bus.in_data;
`endif
          if (idx_q == LAST_IDX) begin
`ifdef GENOME_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_COMMIT;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_LOAD_A;
          end
        end
      end
`ifdef GENOME_CHECKSUM_EN
      S_CHECK: begin
        if (xfer) begin
          err_d   = err_q | (bus.in_data != csum_q);
          state_d = S_COMMIT;
        end
      end
`endif
      S_COMMIT: begin
        commit_en = !err_q;
        done_d    = !err_q;
        rej_d     = err_q;
        idx_d     = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything, including a commit in flight.
    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      idx_d     = '0;
      err_d     = 1'b0;
      done_d    = 1'b0;
      rej_d     = 1'b0;
      commit_en = 1'b0;
`ifdef GENOME_CHECKSUM_EN
      csum_d    = 8'h00;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      rej_q   <= 1'b0;
`ifdef GENOME_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      done_q  <= done_d;
      rej_q   <= rej_d;
`ifdef GENOME_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign load_done  = done_q;
  assign load_error = rej_q;

  for (genvar k = 0; k < NUM_LE; k++) begin : g_le
    localparam logic [IDX_W-1:0] K_IDX = IDX_W'(k);
    le_cfg_t shadow_q, shadow_d, live_q, live_d;

    always_comb begin
      shadow_d = shadow_q;
      live_d   = live_q;
      if (wr_a && (idx_q == K_IDX)) begin
        shadow_d.ins_a = bus.in_data[7:3];
        shadow_d.func  = func_e'(bus.in_data[2:0]);
      end
      if (wr_b && (idx_q == K_IDX)) begin
        shadow_d.ins_b = bus.in_data[4:0];
      end
      if (commit_en) begin
        live_d = shadow_q;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        shadow_q <= '0;
        live_q   <= '0;
      end else begin
        shadow_q <= shadow_d;
        live_q   <= live_d;
      end
    end

    assign conf_func_all[FUNC_W*k +: FUNC_W]    = live_q.func;
    assign conf_ins_all[2*SEL_W*k +: 2*SEL_W]   = {live_q.ins_b, live_q.ins_a};
  end

endmodule

// File: tb/tb_genome_loader.sv
module tb_genome_loader;

  localparam int N    = 18;
  localparam int NB   = 2 * N;
  localparam int NINP = 26;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic abort = 1'b0;
  logic [3*N-1:0]  conf_func_all;
  logic [10*N-1:0] conf_ins_all;
  logic busy, load_done, load_error;

  genome_loader_if bus_if ();

  genome_loader #(.NUM_LE(N), .NUM_INPUTS(NINP)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus_if),
    .abort         (abort),
    .conf_func_all (conf_func_all),
    .conf_ins_all  (conf_ins_all),
    .busy          (busy),
    .load_done     (load_done),
    .load_error    (load_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3*N-1:0]  func;
    logic [10*N-1:0] ins;
    logic            err;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_pushed = 0;
  int n_popped = 0;
  int first_waits;

  logic [7:0]      fr [NB];
  logic [3*N-1:0]  m_func = '0;
  logic [10*N-1:0] m_ins  = '0;

  task automatic check_val(input string tag, input logic [179:0] got, input logic [179:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard: every commit/reject pulse is matched against the oldest queued frame.
  logic pulse_prev = 1'b0;
  always @(negedge clk) begin
    if (!reset && (load_done || load_error)) begin
      check_val("pulse_once", pulse_prev, 0);
      if (sb_q.size() == 0) begin
        check_val("unexpected_pulse", {load_done, load_error}, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        n_popped++;
        check_val("sb_done",  load_done, !e.err);
        check_val("sb_error", load_error, e.err);
        check_val("sb_func",  conf_func_all, e.func);
        check_val("sb_ins",   conf_ins_all, e.ins);
      end
    end
    pulse_prev = !reset && (load_done || load_error);
  end

  task automatic send_byte(input logic [7:0] b, output int waits);
    logic acc;
    acc = 1'b0;
    waits = 0;
    bus_if.in_data  = b;
    bus_if.in_valid = 1'b1;
    while (!acc && waits < 50) begin
      acc = bus_if.in_ready;
      @(negedge clk);
      if (!acc) waits++;
    end
    bus_if.in_valid = 1'b0;
    if (!acc) check_val("byte_timeout", 0, 1);
  endtask

  task automatic base_frame();
    for (int i = 0; i < NB; i++) fr[i] = 8'h00;
    fr[6] = 8'h2B;
    fr[7] = 8'h11;
  endtask

  // Sends the whole frame in fr[] and queues the expected outcome.
  task automatic send_frame(input int gap_max, input bit bad_csum);
    logic [3*N-1:0]  nf;
    logic [10*N-1:0] ni;
    logic [7:0] csum, a, b;
    logic err;
    int w, stalls;
    exp_t e;
    err = 1'b0; csum = 8'h00; nf = '0; ni = '0;
    for (int k = 0; k < N; k++) begin
      a = fr[2*k];
      b = fr[2*k+1];
      csum = csum ^ a ^ b;
      if (int'(a[7:3]) >= NINP || int'(b[4:0]) >= NINP) err = 1'b1;
      nf[3*k +: 3]   = a[2:0];
      ni[10*k +: 10] = {b[4:0], a[7:3]};
    end
    stalls = 0;
    for (int i = 0; i < NB; i++) begin
      bus_if.in_valid = 1'b0;
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      send_byte(fr[i], w);
      if (i == 0) first_waits = w;
      else stalls += w;
    end
`ifdef GENOME_CHECKSUM_EN
    begin
      logic [7:0] cb;
      cb = bad_csum ? 8'h00 : csum;
      if (cb != csum) err = 1'b1;
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      send_byte(cb, w);
      stalls += w;
    end
`else
    if (bad_csum) err = err;
`endif
    check_val("ready_stall", stalls, 0);
    check_val("commit_ready", bus_if.in_ready, 0);
    check_val("commit_busy", busy, 1);
    e.err  = err;
    e.func = err ? m_func : nf;
    e.ins  = err ? m_ins  : ni;
    sb_q.push_back(e);
    n_pushed++;
    if (!err) begin
      m_func = nf;
      m_ins  = ni;
    end
  endtask

  initial begin
    int w;
    bus_if.in_data  = 8'h00;
    bus_if.in_valid = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check_val("rst_ready", bus_if.in_ready, 0);
    check_val("rst_busy",  busy, 0);
    check_val("rst_pulse", {load_done, load_error}, 0);
    check_val("rst_func",  conf_func_all, 0);
    check_val("rst_ins",   conf_ins_all, 0);
    reset = 1'b0;
    @(negedge clk);
    check_val("post_rst_ready", bus_if.in_ready, 1);

    // Basic frame, fixed expectations for element 3
    base_frame();
    send_frame(0, 1'b0);
    @(negedge clk);
    check_val("done_latency", load_done, 1);
    check_val("e3_func", conf_func_all[11:9], 3'd3);
    check_val("e3_ins",  conf_ins_all[39:30], 10'h225);
    check_val("idle_after", busy, 0);
    repeat (2) @(negedge clk);

    // Backpressure, then a frame whose first byte is offered during COMMIT
    base_frame();
    send_frame(3, 1'b0);
    fr[34] = 8'h4E;
    fr[35] = 8'h19;
    send_frame(0, 1'b0);
    check_val("commit_offer_wait", first_waits, 1);
    repeat (3) @(negedge clk);

    // Range rejects: select 27 in ins_a, then select 26 in ins_b
    base_frame();
    fr[0] = 8'hD8;
    send_frame(1, 1'b0);
    @(negedge clk);
    check_val("range_a_err", load_error, 1);
    base_frame();
    fr[1] = 8'h1A;
    send_frame(0, 1'b0);
    repeat (3) @(negedge clk);

    // Abort after 7 bytes, together with a valid byte
    base_frame();
    fr[10] = 8'h61;
    for (int i = 0; i < 7; i++) send_byte(fr[i], w);
    bus_if.in_data  = fr[7];
    bus_if.in_valid = 1'b1;
    abort = 1'b1;
    check_val("abort_ready", bus_if.in_ready, 1);
    @(negedge clk);
    abort = 1'b0;
    bus_if.in_valid = 1'b0;
    check_val("abort_busy", busy, 0);
    repeat (2) @(negedge clk);
    check_val("abort_func", conf_func_all, m_func);
    check_val("abort_ins",  conf_ins_all, m_ins);
    send_frame(2, 1'b0);
    repeat (3) @(negedge clk);

    // Checksum: bad checksum byte rejects; without the feature the frame commits
    base_frame();
    fr[20] = 8'h2B;
    send_frame(0, 1'b1);
    repeat (3) @(negedge clk);

    // Reset in the middle of a frame
    base_frame();
    fr[12] = 8'hC5;
    for (int i = 0; i < 20; i++) send_byte(fr[i], w);
    reset = 1'b1;
    @(negedge clk);
    check_val("midrst_ready", bus_if.in_ready, 0);
    check_val("midrst_busy",  busy, 0);
    check_val("midrst_func",  conf_func_all, 0);
    check_val("midrst_ins",   conf_ins_all, 0);
    m_func = '0;
    m_ins  = '0;
    reset = 1'b0;
    @(negedge clk);
    check_val("midrst_idle", busy, 0);
    send_frame(1, 1'b0);

    // Drain scoreboard
    for (int c = 0; c < 20 && sb_q.size() != 0; c++) @(negedge clk);
    check_val("sb_drain", sb_q.size(), 0);
    check_val("pulse_count", n_popped, n_pushed);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got %0d checks expected completion", n_checks);
    $fatal(1);
  end

endmodule
